// File: rtl/cpu_regs_pkg.sv
// Shared CPU register-block definitions: operation codes and register indices
// used by the index register bank and the blocks that will reuse it.
package cpu_regs_pkg;

    typedef enum logic [2:0] {
        NOP  = 3'd0,
        LOAD = 3'd1,
        INC  = 3'd2,
        DEC  = 3'd3,
        XFER = 3'd4
    } reg_op_t;

    localparam int REG_X = 0;
    localparam int REG_Y = 1;

endpackage

// File: rtl/index_reg_file_if.sv
// System-bus / sequencer side of the index register bank.
// The master is the sequencer and bus mux; the slave is the register file.
interface index_reg_file_if #(
    parameter int WIDTH = 8,
    parameter int SEL_W = 1
);
    logic [WIDTH-1:0] systemBus_IN;
    logic [2:0]       op_IN;
    logic             opValid_EN;
    logic [SEL_W-1:0] dstSel_IN;
    logic [SEL_W-1:0] srcSel_IN;
    logic             systemBusWrite_EN;
    logic [SEL_W-1:0] rdSel_IN;
    logic [WIDTH-1:0] systemBus_OUT;
    logic             systemBusDrive_OUT;
    logic             flagN_OUT;
    logic             flagZ_OUT;
    logic             flagsUpdate_OUT;
    logic             selError_OUT;

    modport master (
        output systemBus_IN, op_IN, opValid_EN, dstSel_IN, srcSel_IN,
               systemBusWrite_EN, rdSel_IN,
        input  systemBus_OUT, systemBusDrive_OUT, flagN_OUT, flagZ_OUT,
               flagsUpdate_OUT, selError_OUT
    );

    modport slave (
        input  systemBus_IN, op_IN, opValid_EN, dstSel_IN, srcSel_IN,
               systemBusWrite_EN, rdSel_IN,
        output systemBus_OUT, systemBusDrive_OUT, flagN_OUT, flagZ_OUT,
               flagsUpdate_OUT, selError_OUT
    );
endinterface

// File: rtl/nz_flag_gen.sv
// Combinational negative/zero flag generator for a WIDTH-bit result.
module nz_flag_gen #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] value,
    output logic             n,
    output logic             z
);
    assign n = value[WIDTH-1];
    assign z = (value == '0);
endmodule

// File: rtl/index_reg_file.sv
// Bank of NUM_REGS index registers with load/inc/dec/transfer and N/Z flags.
// One operation per cycle, results and flags registered on the rising edge.
module index_reg_file
    import cpu_regs_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int NUM_REGS = 2,
    parameter int SEL_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic clk,
    input  logic rst,
    index_reg_file_if.slave bus
);
    // Array spans the whole select space so any select indexes it safely;
    // entries at or above NUM_REGS are never written and stay zero.
    localparam int unsigned DEPTH = 2 ** SEL_W;
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] regs [DEPTH];
    logic [WIDTH-1:0] result;
    logic             do_write;
    logic             sel_err;
    logic             dst_ok;
    logic             src_ok;
    logic             rd_ok;
    logic             res_n;
    logic             res_z;
    logic             flag_n;
    logic             flag_z;
    logic             flags_upd;
    logic             sel_err_q;
    reg_op_t          op;

    assign op     = reg_op_t'(bus.op_IN);
    assign dst_ok = int'(32'(bus.dstSel_IN)) < NUM_REGS;
    assign src_ok = int'(32'(bus.srcSel_IN)) < NUM_REGS;
    assign rd_ok  = int'(32'(bus.rdSel_IN)) < NUM_REGS;

    always_comb begin
        result   = '0;
        do_write = 1'b0;
        sel_err  = 1'b0;
        if (bus.opValid_EN) begin
            case (op)
                NOP: do_write = 1'b0;
                LOAD: begin
                    result   = bus.systemBus_IN;
                    do_write = dst_ok;
                    sel_err  = !dst_ok;
                end
                INC: begin
                    result   = regs[bus.dstSel_IN] + ONE;
                    do_write = dst_ok;
                    sel_err  = !dst_ok;
                end
                DEC: begin
                    result   = regs[bus.dstSel_IN] - ONE;
                    do_write = dst_ok;
                    sel_err  = !dst_ok;
                end
                XFER: begin
                    result   = regs[bus.srcSel_IN];
                    do_write = dst_ok && src_ok;
                    sel_err  = !(dst_ok && src_ok);
                end
                default: sel_err = 1'b1;
            endcase
        end
    end

    nz_flag_gen #(.WIDTH(WIDTH)) u_nz (
        .value (result),
        .n     (res_n),
        .z     (res_z)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            flag_n    <= 1'b0;
            flag_z    <= 1'b0;
            flags_upd <= 1'b0;
            sel_err_q <= 1'b0;
        end else begin
            flags_upd <= do_write;
            sel_err_q <= sel_err;
            if (do_write) begin
                regs[bus.dstSel_IN] <= result;
                flag_n              <= res_n;
                flag_z              <= res_z;
            end
        end
    end

    assign bus.systemBus_OUT      = (bus.systemBusWrite_EN && rd_ok) ? regs[bus.rdSel_IN] : '0;
    assign bus.systemBusDrive_OUT = bus.systemBusWrite_EN && rd_ok;
    assign bus.flagN_OUT          = flag_n;
    assign bus.flagZ_OUT          = flag_z;
    assign bus.flagsUpdate_OUT    = flags_upd;
    assign bus.selError_OUT       = sel_err_q;

endmodule

// File: tb/tb_index_reg_file.sv
// Directed-vector bench for index_reg_file: an 8-bit/2-register bank with a
// widened select (so select 2 is out of range) and a 16-bit/4-register bank.
module tb_index_reg_file;
    import cpu_regs_pkg::*;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_bad;

    index_reg_file_if #(.WIDTH(8),  .SEL_W(2)) b8 ();
    index_reg_file_if #(.WIDTH(16), .SEL_W(2)) b16 ();

    index_reg_file #(.WIDTH(8), .NUM_REGS(2), .SEL_W(2)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (b8)
    );

    index_reg_file #(.WIDTH(16), .NUM_REGS(4)) dut16 (
        .clk (clk),
        .rst (rst),
        .bus (b16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic op8(input logic [2:0] op, input logic [1:0] dst,
                       input logic [1:0] src, input logic [7:0] data);
        @(negedge clk);
        b8.op_IN        = op;
        b8.dstSel_IN    = dst;
        b8.srcSel_IN    = src;
        b8.systemBus_IN = data;
        b8.opValid_EN   = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle8();
        @(negedge clk);
        b8.opValid_EN = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic rd8(input logic [1:0] sel, output logic [7:0] v, output logic drv);
        b8.rdSel_IN          = sel;
        b8.systemBusWrite_EN = 1'b1;
        #1;
        v   = b8.systemBus_OUT;
        drv = b8.systemBusDrive_OUT;
    endtask

    task automatic op16(input logic [2:0] op, input logic [1:0] dst, input logic [15:0] data);
        @(negedge clk);
        b16.op_IN        = op;
        b16.dstSel_IN    = dst;
        b16.srcSel_IN    = 2'd0;
        b16.systemBus_IN = data;
        b16.opValid_EN   = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic rd16(input logic [1:0] sel, output logic [15:0] v);
        b16.rdSel_IN          = sel;
        b16.systemBusWrite_EN = 1'b1;
        #1;
        v = b16.systemBus_OUT;
    endtask

    logic [7:0]  v8;
    logic [15:0] v16;
    logic        drv;

    initial begin
        n_vec = 0;
        n_bad = 0;
        rst   = 1'b1;
        b8.systemBus_IN = '0;  b8.op_IN = '0;  b8.opValid_EN = 1'b0;
        b8.dstSel_IN = '0;  b8.srcSel_IN = '0;  b8.systemBusWrite_EN = 1'b0;  b8.rdSel_IN = '0;
        b16.systemBus_IN = '0; b16.op_IN = '0; b16.opValid_EN = 1'b0;
        b16.dstSel_IN = '0; b16.srcSel_IN = '0; b16.systemBusWrite_EN = 1'b0; b16.rdSel_IN = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Non-zero state first so the asynchronous reset has something to clear
        op8(LOAD, 2'(REG_X), 2'd0, 8'hFF);
        check("pre_rst_n", 32'(b8.flagN_OUT), 32'd1);

        // Reset asserted between edges while a LOAD 0x5A is pending
        @(negedge clk);
        b8.op_IN = LOAD; b8.dstSel_IN = 2'(REG_X); b8.systemBus_IN = 8'h5A; b8.opValid_EN = 1'b1;
        #2 rst = 1'b1;
        #1;
        check("rst_async_n", 32'(b8.flagN_OUT), 32'd0);
        b8.opValid_EN = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rst_n", 32'(b8.flagN_OUT), 32'd0);
        check("rst_z", 32'(b8.flagZ_OUT), 32'd0);
        check("rst_upd", 32'(b8.flagsUpdate_OUT), 32'd0);
        check("rst_selerr", 32'(b8.selError_OUT), 32'd0);
        rd8(2'(REG_X), v8, drv);
        check("rst_x", 32'(v8), 32'h00);

        // LOAD 0x80 to X
        op8(LOAD, 2'(REG_X), 2'd0, 8'h80);
        check("ld80_upd", 32'(b8.flagsUpdate_OUT), 32'd1);
        check("ld80_n", 32'(b8.flagN_OUT), 32'd1);
        check("ld80_z", 32'(b8.flagZ_OUT), 32'd0);
        rd8(2'(REG_X), v8, drv);
        check("ld80_x", 32'(v8), 32'h80);
        check("ld80_drv", 32'(drv), 32'd1);
        idle8();
        check("ld80_upd_off", 32'(b8.flagsUpdate_OUT), 32'd0);
        check("ld80_n_hold", 32'(b8.flagN_OUT), 32'd1);
        b8.systemBusWrite_EN = 1'b0;
        #1;
        check("noread_bus", 32'(b8.systemBus_OUT), 32'h00);
        check("noread_drv", 32'(b8.systemBusDrive_OUT), 32'd0);

        // Wrap-around on Y, then back-to-back INC INC
        op8(LOAD, 2'(REG_Y), 2'd0, 8'hFF);
        op8(INC, 2'(REG_Y), 2'd0, 8'h00);
        rd8(2'(REG_Y), v8, drv);
        check("inc_wrap_y", 32'(v8), 32'h00);
        check("inc_wrap_z", 32'(b8.flagZ_OUT), 32'd1);
        check("inc_wrap_n", 32'(b8.flagN_OUT), 32'd0);
        check("inc_wrap_upd", 32'(b8.flagsUpdate_OUT), 32'd1);
        op8(DEC, 2'(REG_Y), 2'd0, 8'h00);
        rd8(2'(REG_Y), v8, drv);
        check("dec_wrap_y", 32'(v8), 32'hFF);
        check("dec_wrap_n", 32'(b8.flagN_OUT), 32'd1);
        check("dec_wrap_z", 32'(b8.flagZ_OUT), 32'd0);
        op8(INC, 2'(REG_Y), 2'd0, 8'h00);
        op8(INC, 2'(REG_Y), 2'd0, 8'h00);
        rd8(2'(REG_Y), v8, drv);
        check("inc2_y", 32'(v8), 32'h01);
        check("inc2_z", 32'(b8.flagZ_OUT), 32'd0);

        // XFER X->Y with a read of Y in the op cycle
        op8(LOAD, 2'(REG_X), 2'd0, 8'h00);
        op8(LOAD, 2'(REG_Y), 2'd0, 8'h33);
        @(negedge clk);
        b8.op_IN = XFER; b8.dstSel_IN = 2'(REG_Y); b8.srcSel_IN = 2'(REG_X); b8.opValid_EN = 1'b1;
        rd8(2'(REG_Y), v8, drv);
        check("xfer_old_y", 32'(v8), 32'h33);
        @(posedge clk);
        #1;
        rd8(2'(REG_Y), v8, drv);
        check("xfer_new_y", 32'(v8), 32'h00);
        check("xfer_z", 32'(b8.flagZ_OUT), 32'd1);

        // XFER with src == dst still refreshes flags
        op8(LOAD, 2'(REG_Y), 2'd0, 8'h44);
        check("ld44_z", 32'(b8.flagZ_OUT), 32'd0);
        op8(XFER, 2'(REG_X), 2'(REG_X), 8'h00);
        check("xself_z", 32'(b8.flagZ_OUT), 32'd1);
        check("xself_upd", 32'(b8.flagsUpdate_OUT), 32'd1);
        rd8(2'(REG_X), v8, drv);
        check("xself_x", 32'(v8), 32'h00);

        // Out-of-range selects and illegal op code
        op8(INC, 2'd2, 2'd0, 8'h00);
        check("oor_inc_err", 32'(b8.selError_OUT), 32'd1);
        check("oor_inc_upd", 32'(b8.flagsUpdate_OUT), 32'd0);
        check("oor_inc_z", 32'(b8.flagZ_OUT), 32'd1);
        op8(3'd6, 2'(REG_Y), 2'd0, 8'h00);
        check("op6_err", 32'(b8.selError_OUT), 32'd1);
        check("op6_upd", 32'(b8.flagsUpdate_OUT), 32'd0);
        op8(XFER, 2'(REG_Y), 2'd3, 8'h00);
        check("oor_src_err", 32'(b8.selError_OUT), 32'd1);
        rd8(2'(REG_Y), v8, drv);
        check("oor_y", 32'(v8), 32'h44);
        rd8(2'(REG_X), v8, drv);
        check("oor_x", 32'(v8), 32'h00);
        op8(NOP, 2'd3, 2'd3, 8'h00);
        check("nop_err", 32'(b8.selError_OUT), 32'd0);
        idle8();
        check("idle_err", 32'(b8.selError_OUT), 32'd0);
        rd8(2'd2, v8, drv);
        check("rd_oor_bus", 32'(v8), 32'h00);
        check("rd_oor_drv", 32'(drv), 32'd0);

        // 16-bit, 4-register instance
        op16(LOAD, 2'd0, 16'h1234);
        op16(LOAD, 2'd1, 16'hABCD);
        op16(LOAD, 2'd2, 16'h8001);
        op16(LOAD, 2'd3, 16'hFFFF);
        check("w16_ld_n", 32'(b16.flagN_OUT), 32'd1);
        op16(INC, 2'd3, 16'h0000);
        check("w16_inc_z", 32'(b16.flagZ_OUT), 32'd1);
        check("w16_inc_n", 32'(b16.flagN_OUT), 32'd0);
        rd16(2'd3, v16);
        check("w16_r3", 32'(v16), 32'h0000);
        rd16(2'd0, v16);
        check("w16_r0", 32'(v16), 32'h1234);
        rd16(2'd1, v16);
        check("w16_r1", 32'(v16), 32'hABCD);
        rd16(2'd2, v16);
        check("w16_r2", 32'(v16), 32'h8001);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/index_reg_file.md
Name: index_reg_file

Overview:
- Clocked, parametrised successor to the single latch-based index register: a bank of NUM_REGS index registers (X, Y, ...) on the CPU system bus.
- Adds synchronous load, increment, decrement and register-to-register transfer, plus N/Z flag generation for the status register.
- Sits between the system bus and the P-register flag-update logic. The microcode sequencer drives it one operation per cycle.

Parameters:
- WIDTH, 8, data width of each register and of the bus.
- NUM_REGS, 2, number of index registers (index 0 = X, 1 = Y).
- SEL_W, $clog2(NUM_REGS) with a minimum of 1, width of register-select fields.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- systemBus_IN  input  WIDTH  bus data, used by LOAD.
- op_IN  input  3  operation code (reg_op_t).
- opValid_EN  input  1  perform op_IN this cycle.
- dstSel_IN  input  SEL_W  destination register for LOAD/INC/DEC/XFER.
- srcSel_IN  input  SEL_W  source register for XFER.
- systemBusWrite_EN  input  1  drive the selected register onto the bus.
- rdSel_IN  input  SEL_W  register presented on systemBus_OUT.
- systemBus_OUT  output  WIDTH  read data.
- systemBusDrive_OUT  output  1  systemBus_OUT is valid and must be driven onto the bus.
- flagN_OUT  output  1  registered N result.
- flagZ_OUT  output  1  registered Z result.
- flagsUpdate_OUT  output  1  one-cycle pulse: flags are fresh.
- selError_OUT  output  1  one-cycle pulse: an out-of-range select was used.

Behaviour:
- Reset (asynchronous, any time, including mid-operation): all registers = 0, flagN_OUT = 0, flagZ_OUT = 0, flagsUpdate_OUT = 0, selError_OUT = 0. Any operation in progress is discarded.
- Ops, applied when opValid_EN = 1, updating on the next rising edge (latency 1):
  - NOP = 0: no change.
  - LOAD = 1: reg[dst] <= systemBus_IN.
  - INC = 2: reg[dst] <= reg[dst] + 1, modulo 2^WIDTH.
  - DEC = 3: reg[dst] <= reg[dst] - 1, modulo 2^WIDTH.
  - XFER = 4: reg[dst] <= reg[src].
  - Codes 5-7: treated as NOP, and selError_OUT pulses.
- Flags, for LOAD/INC/DEC/XFER:
  - The registered result R is computed from the new value: flagN_OUT <= R[WIDTH-1], flagZ_OUT <= (R == 0).
  - flagsUpdate_OUT = 1 for exactly the cycle after the op.
  - Flags hold their value otherwise.
- Wrap-around: INC of 2^WIDTH-1 gives 0 (Z=1, N=0). DEC of 0 gives 2^WIDTH-1 (N=1, Z=0). No carry output.
- XFER with src == dst: register unchanged, flags still updated from its value.
- Out-of-range select: if dst or src (when used by the op) is >= NUM_REGS, the op is suppressed, flags are unchanged, flagsUpdate_OUT stays 0 and selError_OUT pulses for one cycle.
- Read path (combinational from state):
  - systemBus_OUT = reg[rdSel_IN] when systemBusWrite_EN = 1 and rdSel_IN is in range; otherwise 0.
  - systemBusDrive_OUT = systemBusWrite_EN and rdSel_IN in range.
  - The block itself never drives Z; the top-level bus mux owns tri-stating.
- Read during write: the read returns the pre-edge (old) value; the new value is visible from the next cycle.
- opValid_EN = 0: no state change; flagsUpdate_OUT and selError_OUT are 0 next cycle.
- One op per cycle. Back-to-back ops on the same register chain correctly, e.g. INC then INC gives +2 after two edges.

Decomposition:
- Shared package cpu_regs_pkg:
  - typedef enum logic [2:0] reg_op_t with values NOP, LOAD, INC, DEC, XFER.
  - localparams REG_X = 0 and REG_Y = 1.
- One natural sub-module: nz_flag_gen.
  - Combinational, parametrised on WIDTH.
  - Input: value. Outputs: n, z.
  - Reused later by the accumulator and ALU blocks.

Test Plan:
- Reset mid-op: LOAD 0x5A to X, assert rst asynchronously within that same cycle. -> X = 0, all flags 0, flagsUpdate_OUT = 0, bus read of X returns 0x00.
- LOAD 0x80 to X, then read X. -> systemBus_OUT = 0x80 with systemBusDrive_OUT = 1; N = 1, Z = 0; flagsUpdate_OUT pulses once.
- Wrap: LOAD 0xFF to Y, INC Y. -> Y = 0x00, Z = 1, N = 0. Then DEC Y. -> Y = 0xFF, N = 1, Z = 0.
- XFER X->Y with X = 0x00 and Y = 0x33, reading Y in the same cycle. -> read returns 0x33; the next cycle Y = 0x00 and Z = 1.
- Out-of-range select: dstSel = 2 with NUM_REGS = 2, op INC. -> no register changes, selError_OUT pulses, flagsUpdate_OUT = 0. Op code 6 behaves the same way.
- Parameter sweep: WIDTH = 16, NUM_REGS = 4; INC 0xFFFF in reg 3. -> 0x0000, Z = 1; the other registers are untouched.
